uart_receiver: RTL

Serial-to-byte front end of the display command path: it oversamples the host UART line, frames 8-bit LSB-first characters and presents each good byte as a one-cycle strobe on the `o_Rx_DV`/`o_Rx_Byte` pair consumed by `instruction_engine`. Corrupt frames are dropped and flagged, never forwarded, so the downstream command/pixel byte stream stays aligned.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_receiver.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame width, parity sense
// and the default baud divider (also used by the planned transmitter).
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        s_IDLE      = 3'd0,
        s_START     = 3'd1,
        s_DATA      = 3'd2,
        s_PARITY    = 3'd3,
        s_STOP      = 3'd4,
        s_WAIT_IDLE = 3'd5
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer; both flops reset to RESET_VAL.
module sync_2ff #(
    parameter bit RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver, 8 data bits LSB-first, 1 stop bit.
// Define UART_RX_PARITY_EN to add a parity bit (sense set by PARITY_ODD).
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter bit PARITY_ODD   = PAR_EVEN
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Frame_Error,
    output logic                 o_Parity_Error
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    rx_state_t            state;
    logic [CNT_W-1:0]     timer;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (i_Clock),
        .rst (i_Reset),
        .d   (i_Rx_Serial),
        .q   (rx)
    );

`ifdef UART_RX_PARITY_EN
    logic par_err;
`else
    assign o_Parity_Error = 1'b0;
`endif

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state         <= s_IDLE;
            timer         <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            o_Rx_DV       <= 1'b0;
            o_Rx_Byte     <= '0;
            o_Frame_Error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err        <= 1'b0;
            o_Parity_Error <= 1'b0;
`endif
        end else begin
            o_Rx_DV       <= 1'b0;
            o_Frame_Error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_Parity_Error <= 1'b0;
`endif
            // Timer free-runs inside a bit; every transition below clears it.
            timer <= timer + 1'b1;
            case (state)
                s_IDLE: begin
                    timer <= '0;
                    if (!rx) state <= s_START;
                end
                s_START: begin
                    if (timer == CNT_HALF) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= rx ? s_IDLE : s_DATA;
                    end
                end
                s_DATA: begin
                    if (timer == CNT_LAST) begin
                        timer   <= '0;
                        shreg   <= {rx, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= s_PARITY;
`else
                            state <= s_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                s_PARITY: begin
                    if (timer == CNT_LAST) begin
                        timer   <= '0;
                        par_err <= rx != ((^shreg) ^ (PARITY_ODD == PAR_ODD));
                        state   <= s_STOP;
                    end
                end
`endif
                s_STOP: begin
                    if (timer == CNT_LAST) begin
                        timer <= '0;
                        // A bad stop bit outranks parity: the frame is misaligned.
                        if (!rx) begin
                            o_Frame_Error <= 1'b1;
                            state         <= s_WAIT_IDLE;
                        end else begin
                            state <= s_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_err) begin
                                o_Parity_Error <= 1'b1;
                            end else begin
                                o_Rx_Byte <= shreg;
                                o_Rx_DV   <= 1'b1;
                            end
`else
                            o_Rx_Byte <= shreg;
                            o_Rx_DV   <= 1'b1;
`endif
                        end
                    end
                end
                s_WAIT_IDLE: begin
                    timer <= '0;
                    if (rx) state <= s_IDLE;
                end
                default: begin
                    timer <= '0;
                    state <= s_IDLE;
                end
            endcase
        end
    end

endmodule
